// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module      : mul_div_unit_pkg
// Description : Shared constants for the HI/LO multiply/divide unit: default
//               word width, operation encodings and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mul_div_unit_pkg;

   // Operation codes as presented on the op port
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

endpackage : mul_div_unit_pkg

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative HI/LO multiply/divide unit. Shift-add multiply and
//               restoring divide on operand magnitudes, one bit per cycle,
//               followed by a sign fix-up cycle that writes HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WORD_WIDTH = `WORD_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [WORD_WIDTH-1:0] srcA,
   input  logic [WORD_WIDTH-1:0] srcB,
   input  logic                  cancel,
   output logic                  busy,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] hi,
   output logic [WORD_WIDTH-1:0] lo
);

   localparam int W     = WORD_WIDTH;
   localparam int CNT_W = $clog2(WORD_WIDTH + 1);

   md_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   // MUL: {partial product, remaining multiplier bits}
   // DIV: {partial remainder, dividend bits shifting into quotient}
   logic [2*W-1:0]       acc_q, acc_d;
   // Multiplicand for MUL, divisor for DIV (magnitude for signed ops)
   logic [W-1:0]         opnd_q, opnd_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_res_q, neg_res_d;
   logic                 neg_rem_q, neg_rem_d;
   logic [W-1:0]         hi_q, hi_d;
   logic [W-1:0]         lo_q, lo_d;
   logic                 done_q, done_d;

   // Operand conditioning at issue
   logic                 is_signed;
   logic [W-1:0]         a_use, b_use;

   // Iteration datapath
   logic [W:0]           mul_sum;
   logic [2*W-1:0]       mul_next;
   logic [W:0]           div_part;
   logic [W:0]           div_diff;
   logic [2*W-1:0]       div_next;

   // Fix-up results
   logic [2*W-1:0]       prod_fix;
   logic [W-1:0]         quo_fix;
   logic [W-1:0]         rem_fix;

   // Operand magnitudes for signed ops, raw operands for unsigned ops
   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      a_use     = srcA;
      b_use     = srcB;
      if (is_signed && srcA[W-1]) a_use = ~srcA + 1'b1;
      if (is_signed && srcB[W-1]) b_use = ~srcB + 1'b1;
   end

   // One shift-add step and one restoring-divide step on the accumulator
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
      mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                          : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};
      div_part = {acc_q[2*W-1:W], acc_q[W-1]};
      div_diff = div_part - {1'b0, opnd_q};
      // A borrow restores the shifted remainder; the quotient bit is 0
      div_next = div_diff[W] ? {div_part[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
   end

   // Sign fix-up; a zero divisor forces an all-ones quotient and the
   // remainder naturally equals the dividend after sign restoration
   always_comb begin
      prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      rem_fix  = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
      if (opnd_q == '0)   quo_fix = '1;
      else if (neg_res_q) quo_fix = ~acc_q[W-1:0] + 1'b1;
      else                quo_fix = acc_q[W-1:0];
   end

   // Next-state, iteration and HI/LO write control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_MTHI: hi_d = srcA;
                  OP_MTLO: lo_d = srcA;
                  OP_MULT, OP_MULTU: begin
                     state_d   = ST_MUL;
                     acc_d     = {{W{1'b0}}, b_use};
                     opnd_d    = a_use;
                     is_div_d  = 1'b0;
                     neg_res_d = is_signed & (srcA[W-1] ^ srcB[W-1]);
                     neg_rem_d = is_signed & srcA[W-1];
                     cnt_d     = CNT_W'(WORD_WIDTH);
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d   = ST_DIV;
                     acc_d     = {{W{1'b0}}, a_use};
                     opnd_d    = b_use;
                     is_div_d  = 1'b1;
                     neg_res_d = is_signed & (srcA[W-1] ^ srcB[W-1]);
                     neg_rem_d = is_signed & srcA[W-1];
                     cnt_d     = CNT_W'(WORD_WIDTH);
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (cancel) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               acc_d = mul_next;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DIV: begin
            if (cancel) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               acc_d = div_next;
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!cancel) begin
               done_d = 1'b1;
               if (is_div_d) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*W-1:W];
                  lo_d = prod_fix[W-1:0];
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule : mul_div_unit

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit (W=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        cancel;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks;
   int n_errors;

   // Bench-side copy of the architectural HI/LO contents
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mul_div_unit #(.WORD_WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .srcA   (srcA),
      .srcB   (srcB),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, track busy length, then check result, done pulse and HI/LO
   // stability while busy. Optionally re-asserts start 5 cycles in.
   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit retrigger);
      int  cycles;
      bit  finished;
      bit  stable;
      @(negedge clk);
      op = o; srcA = a; srcB = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (retrigger) begin
         op = OP_MULT; srcA = 32'd3; srcB = 32'd3;
      end
      cycles = 0; finished = 0; stable = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (!busy) begin
            finished = 1;
            break;
         end
         cycles++;
         if (hi !== m_hi || lo !== m_lo) stable = 0;
         if (retrigger && cycles == 5) start = 1'b1;
      end
      check_val({tag, "_finished"}, 64'(finished), 64'd1);
      check_val({tag, "_busy_len"}, 64'(cycles), 64'd34);
      check_val({tag, "_stable"},   64'(stable), 64'd1);
      check_val({tag, "_done"},     64'(done), 64'd1);
      check_val({tag, "_hi"},       64'(hi), 64'(exp_hi));
      check_val({tag, "_lo"},       64'(lo), 64'(exp_lo));
      m_hi = exp_hi;
      m_lo = exp_lo;
      @(negedge clk);
      check_val({tag, "_done_off"}, 64'(done), 64'd0);
      check_val({tag, "_idle"},     64'(busy), 64'd0);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      m_hi = '0; m_lo = '0;
      rst_n = 1'b0; start = 1'b0; op = '0; srcA = '0; srcB = '0; cancel = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_hi",   64'(hi),   64'd0);
      check_val("rst_lo",   64'(lo),   64'd0);
      rst_n = 1'b1;

      run_op("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
      run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
      run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0);
      run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
      run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0);
      run_op("divu_ff_16", OP_DIVU, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 0);
      run_op("div_by0", OP_DIV, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0);
      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0);
      run_op("div_retrig", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1);

      // Cancel about 10 cycles into a multiply
      @(negedge clk);
      op = OP_MULTU; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      check_val("cancel_pre_busy", 64'(busy), 64'd1);
      cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      @(negedge clk);
      check_val("cancel_busy", 64'(busy), 64'd0);
      check_val("cancel_done", 64'(done), 64'd0);
      check_val("cancel_hi",   64'(hi),   64'd2);
      check_val("cancel_lo",   64'(lo),   64'd14);
      @(negedge clk);
      check_val("cancel_done2", 64'(done), 64'd0);

      // Reserved op code is ignored
      op = 3'd6; srcA = 32'h55; srcB = 32'h1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check_val("rsvd_busy", 64'(busy), 64'd0);
      check_val("rsvd_hi",   64'(hi),   64'd2);
      check_val("rsvd_lo",   64'(lo),   64'd14);

      // MTHI (with cancel held, which must not block it) then MTLO back-to-back
      op = OP_MTHI; srcA = 32'hDEADBEEF; start = 1'b1; cancel = 1'b1;
      @(posedge clk);
      #1 cancel = 1'b0;
      @(negedge clk);
      check_val("mthi_hi",   64'(hi),   64'hDEADBEEF);
      check_val("mthi_lo",   64'(lo),   64'd14);
      check_val("mthi_busy", 64'(busy), 64'd0);
      check_val("mthi_done", 64'(done), 64'd0);
      op = OP_MTLO; srcA = 32'h0BADF00D;
      @(negedge clk);
      start = 1'b0;
      check_val("mtlo_lo",   64'(lo),   64'h0BADF00D);
      check_val("mtlo_hi",   64'(hi),   64'hDEADBEEF);
      check_val("mtlo_busy", 64'(busy), 64'd0);
      check_val("mtlo_done", 64'(done), 64'd0);
      m_hi = 32'hDEADBEEF;
      m_lo = 32'h0BADF00D;

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      op = OP_MULTU; srcA = 32'd9; srcB = 32'd9; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("arst_busy", 64'(busy), 64'd0);
      check_val("arst_done", 64'(done), 64'd0);
      check_val("arst_hi",   64'(hi),   64'd0);
      check_val("arst_lo",   64'(lo),   64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      m_hi = '0;
      m_lo = '0;

      run_op("post_rst_multu", OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mul_div_unit

`default_nettype wire
